// File: rtl/key_event_scheduler_if.sv
// Purpose: bundles the two key-event requester ports and the engine write port of
//          key_event_scheduler.
// Ports:
//   a_* / b_*   requester events (valid, ready, on, voice, key, vel)
//   eng_*       engine register write port (wr, voice, sel, data, busy)
//   gate        per-voice gate vector
//   sched_idle  scheduler idle
// Modports: slave = scheduler side, master = requester/engine (bench) side.
interface key_event_scheduler_if #(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned V_WIDTH = 3
);
  logic               a_valid;
  logic               a_ready;
  logic               a_on;
  logic [V_WIDTH-1:0] a_voice;
  logic [7:0]         a_key;
  logic [7:0]         a_vel;

  logic               b_valid;
  logic               b_ready;
  logic               b_on;
  logic [V_WIDTH-1:0] b_voice;
  logic [7:0]         b_key;
  logic [7:0]         b_vel;

  logic               eng_wr;
  logic [V_WIDTH-1:0] eng_voice;
  logic [1:0]         eng_sel;
  logic [7:0]         eng_data;
  logic               eng_busy;

  logic [VOICES-1:0]  gate;
  logic               sched_idle;

  modport slave (
    input  a_valid, a_on, a_voice, a_key, a_vel,
    input  b_valid, b_on, b_voice, b_key, b_vel,
    input  eng_busy,
    output a_ready, b_ready,
    output eng_wr, eng_voice, eng_sel, eng_data,
    output gate, sched_idle
  );

  modport master (
    output a_valid, a_on, a_voice, a_key, a_vel,
    output b_valid, b_on, b_voice, b_key, b_vel,
    output eng_busy,
    input  a_ready, b_ready,
    input  eng_wr, eng_voice, eng_sel, eng_data,
    input  gate, sched_idle
  );
endinterface

// File: rtl/key_event_scheduler.sv
// Purpose: shares the per-voice engine register write port between two key-event
//          requesters (A = note stack, B = sequencer). Each requester feeds a FIFO;
//          an arbiter pops one event at a time in IDLE, and an FSM expands it into
//          ordered key / velocity / gate writes. Keeps the authoritative gate vector.
// Ports:
//   data_clk  system clock (rising edge)
//   reset     asynchronous active-high reset
//   bus       key_event_scheduler_if.slave (requester A/B, engine port, gate, sched_idle)
// Configuration macro: KEY_SCHED_FIXED_PRIO_EN
//   undefined -> round-robin between A and B (A wins first after reset)
//   defined   -> fixed priority, A always wins when non-empty
module key_event_scheduler #(
  parameter int unsigned VOICES     = 8,
  parameter int unsigned V_WIDTH    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FD_WIDTH   = 2
) (
  input logic                  data_clk,
  input logic                  reset,
  key_event_scheduler_if.slave bus
);

  localparam int unsigned CW = FD_WIDTH + 1;

  localparam logic [1:0] SEL_KEY  = 2'd0;
  localparam logic [1:0] SEL_VEL  = 2'd1;
  localparam logic [1:0] SEL_GATE = 2'd2;

  typedef struct packed {
    logic               on;
    logic [V_WIDTH-1:0] voice;
    logic [7:0]         key;
    logic [7:0]         vel;
  } evt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RETRIG, S_WR_KEY, S_WR_VEL, S_WR_GATE
  } state_t;

  // Index 0 = requester A, 1 = requester B
  evt_t                mem_q [2][FIFO_DEPTH];
  logic [FD_WIDTH-1:0] wp_q  [2];
  logic [FD_WIDTH-1:0] rp_q  [2];
  logic [CW-1:0]       cnt_q [2];
  logic [CW-1:0]       cnt_d [2];
  logic [1:0]          ready_q, ready_d;
  logic [1:0]          push, pop, nonempty;
  evt_t                in_evt [2];
  evt_t                head   [2];

  state_t              state_q, state_d;
  evt_t                evt_q, evt_d;
  logic [VOICES-1:0]   gate_q, gate_d;
  logic                eng_wr_q, eng_wr_d;
  logic [V_WIDTH-1:0]  eng_voice_q, eng_voice_d;
  logic [1:0]          eng_sel_q, eng_sel_d;
  logic [7:0]          eng_data_q, eng_data_d;
  logic                sched_idle_q, sched_idle_d;
  logic                wr_done;
  logic                grant_a, grant_b;

  assign in_evt[0] = {bus.a_on, bus.a_voice, bus.a_key, bus.a_vel};
  assign in_evt[1] = {bus.b_on, bus.b_voice, bus.b_key, bus.b_vel};

  // Push only against the registered ready: a full FIFO refuses even while popping
  assign push = {bus.b_valid & ready_q[1], bus.a_valid & ready_q[0]};
  assign pop  = {grant_b, grant_a};

  // FIFO occupancy and next-cycle ready
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head[i]     = mem_q[i][rp_q[i]];
      nonempty[i] = (cnt_q[i] != '0);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      ready_d[i]  = (cnt_d[i] != CW'(FIFO_DEPTH));
    end
  end

`ifdef KEY_SCHED_FIXED_PRIO_EN
  // Fixed priority: A whenever it has an event
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == S_IDLE) begin
      if (nonempty[0])      grant_a = 1'b1;
      else if (nonempty[1]) grant_b = 1'b1;
    end
  end
`else
  // Round-robin: on contention grant whoever was not granted last
  logic last_b_q, last_b_d;

  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    last_b_d = last_b_q;
    if (state_q == S_IDLE) begin
      if (nonempty[0] && nonempty[1]) begin
        grant_a = last_b_q;
        grant_b = !last_b_q;
      end else begin
        grant_a = nonempty[0];
        grant_b = nonempty[1];
      end
      if (grant_a)      last_b_d = 1'b0;
      else if (grant_b) last_b_d = 1'b1;
    end
  end

  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) last_b_q <= 1'b1;
    else       last_b_q <= last_b_d;
  end
`endif

  // Only a write state drives eng_wr, so eng_wr_q marks every write attempt
  assign wr_done = eng_wr_q & ~bus.eng_busy;

  // Sequencer next state, gate bookkeeping and registered engine outputs
  always_comb begin
    state_d      = state_q;
    evt_d        = evt_q;
    gate_d       = gate_q;
    eng_wr_d     = 1'b0;
    eng_sel_d    = SEL_KEY;
    eng_data_d   = 8'h00;
    eng_voice_d  = eng_voice_q;
    sched_idle_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          evt_d = grant_a ? head[0] : head[1];
          if (!evt_d.on)                state_d = S_WR_VEL;
          else if (gate_q[evt_d.voice]) state_d = S_RETRIG;
          else                          state_d = S_WR_KEY;
        end
      end
      S_RETRIG: begin
        if (wr_done) begin
          gate_d[evt_q.voice] = 1'b0;
          state_d             = S_WR_KEY;
        end
      end
      S_WR_KEY:  if (wr_done) state_d = S_WR_VEL;
      S_WR_VEL:  if (wr_done) state_d = S_WR_GATE;
      S_WR_GATE: begin
        if (wr_done) begin
          gate_d[evt_q.voice] = evt_q.on;
          state_d             = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    case (state_d)
      S_RETRIG: begin
        eng_wr_d   = 1'b1;
        eng_sel_d  = SEL_GATE;
        eng_data_d = 8'h00;
      end
      S_WR_KEY: begin
        eng_wr_d   = 1'b1;
        eng_sel_d  = SEL_KEY;
        eng_data_d = evt_d.key;
      end
      S_WR_VEL: begin
        eng_wr_d   = 1'b1;
        eng_sel_d  = SEL_VEL;
        eng_data_d = evt_d.vel;
      end
      S_WR_GATE: begin
        eng_wr_d   = 1'b1;
        eng_sel_d  = SEL_GATE;
        eng_data_d = {7'b0, evt_d.on};
      end
      default: begin
        eng_wr_d = 1'b0;
      end
    endcase
    if (state_d != S_IDLE) eng_voice_d = evt_d.voice;

    sched_idle_d = (state_d == S_IDLE) && (cnt_d[0] == '0) && (cnt_d[1] == '0);
  end

  // FIFO storage needs no reset: pointers and counts define validity
  always_ff @(posedge data_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wp_q[i]] <= in_evt[i];
    end
  end

  // FIFO pointers, counts and ready flags
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      ready_q <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wp_q[i] <= wp_q[i] + FD_WIDTH'(1);
        if (pop[i])  rp_q[i] <= rp_q[i] + FD_WIDTH'(1);
        cnt_q[i] <= cnt_d[i];
      end
      ready_q <= ready_d;
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      evt_q        <= '0;
      gate_q       <= '0;
      eng_wr_q     <= 1'b0;
      eng_voice_q  <= '0;
      eng_sel_q    <= '0;
      eng_data_q   <= '0;
      sched_idle_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      evt_q        <= evt_d;
      gate_q       <= gate_d;
      eng_wr_q     <= eng_wr_d;
      eng_voice_q  <= eng_voice_d;
      eng_sel_q    <= eng_sel_d;
      eng_data_q   <= eng_data_d;
      sched_idle_q <= sched_idle_d;
    end
  end

  assign bus.a_ready    = ready_q[0];
  assign bus.b_ready    = ready_q[1];
  assign bus.eng_wr     = eng_wr_q;
  assign bus.eng_voice  = eng_voice_q;
  assign bus.eng_sel    = eng_sel_q;
  assign bus.eng_data   = eng_data_q;
  assign bus.gate       = gate_q;
  assign bus.sched_idle = sched_idle_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Purpose: self-checking bench for key_event_scheduler: table of single events with
//          cycle-exact write expectations, plus directed arbitration, stall, full-FIFO
//          and reset-mid-sequence sequences.
module tb_key_event_scheduler;

  typedef logic [12:0] wr_t;  // {voice, sel, data}

  typedef struct {
    bit         port_b;
    bit         on;
    logic [2:0] voice;
    logic [7:0] key;
    logic [7:0] vel;
    int         nwr;
    wr_t        wr [4];
    logic [3:0] gv;        // gate[voice] seen on each write cycle
    logic [7:0] gate_exp;  // gate vector once back in IDLE
  } vec_t;

  logic data_clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  wr_t  wlog [$];
  vec_t vt [7];

  key_event_scheduler_if #(.VOICES(8), .V_WIDTH(3)) bus ();

  key_event_scheduler dut (
    .data_clk (data_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 data_clk = ~data_clk;

  // Log of completed engine writes
  always @(posedge data_clk) begin
    if (!reset && bus.eng_wr && !bus.eng_busy)
      wlog.push_back({bus.eng_voice, bus.eng_sel, bus.eng_data});
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic wr_t W(int v, int s, int d);
    return {3'(v), 2'(s), 8'(d)};
  endfunction

  function automatic vec_t mkv(int pb, int on, int v, int k, int vl, int n,
                               wr_t w0, wr_t w1, wr_t w2, wr_t w3, int gv, int ge);
    vec_t r;
    r.port_b = 1'(pb);
    r.on = 1'(on);
    r.voice = 3'(v);
    r.key = 8'(k);
    r.vel = 8'(vl);
    r.nwr = n;
    r.wr[0] = w0;
    r.wr[1] = w1;
    r.wr[2] = w2;
    r.wr[3] = w3;
    r.gv = 4'(gv);
    r.gate_exp = 8'(ge);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.a_valid = 1'b0; bus.a_on = 1'b0; bus.a_voice = '0; bus.a_key = '0; bus.a_vel = '0;
    bus.b_valid = 1'b0; bus.b_on = 1'b0; bus.b_voice = '0; bus.b_key = '0; bus.b_vel = '0;
  endtask

  task automatic drive_a(bit on, int v, int k, int vl);
    bus.a_valid = 1'b1; bus.a_on = on; bus.a_voice = 3'(v); bus.a_key = 8'(k); bus.a_vel = 8'(vl);
  endtask

  task automatic drive_b(bit on, int v, int k, int vl);
    bus.b_valid = 1'b1; bus.b_on = on; bus.b_voice = 3'(v); bus.b_key = 8'(k); bus.b_vel = 8'(vl);
  endtask

  task automatic do_reset();
    @(negedge data_clk);
    reset = 1'b1;
    clear_inputs();
    bus.eng_busy = 1'b0;
    @(negedge data_clk);
    @(negedge data_clk);
    reset = 1'b0;
    wlog.delete();
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    @(negedge data_clk);
    while (!(bus.sched_idle && !bus.eng_wr) && n < budget) begin
      @(negedge data_clk);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_keys [6];
    logic [7:0] keys [$];
    int acc;
    int cnt;
    bit any_wr;

    vt[0] = mkv(0, 1, 2, 60, 100, 3, W(2,0,60), W(2,1,100), W(2,2,1), '0, 4'b0000, 8'h04);
    vt[1] = mkv(0, 1, 2, 64,  90, 4, W(2,2,0),  W(2,0,64),  W(2,1,90), W(2,2,1), 4'b0001, 8'h04);
    vt[2] = mkv(1, 1, 5, 70,  80, 3, W(5,0,70), W(5,1,80),  W(5,2,1), '0, 4'b0000, 8'h24);
    vt[3] = mkv(0, 0, 2,  0,  30, 2, W(2,1,30), W(2,2,0),   '0, '0, 4'b0011, 8'h20);
    vt[4] = mkv(1, 0, 0,  0,  10, 2, W(0,1,10), W(0,2,0),   '0, '0, 4'b0000, 8'h20);
    vt[5] = mkv(1, 0, 5,  0,   0, 2, W(5,1,0),  W(5,2,0),   '0, '0, 4'b0011, 8'h00);
    vt[6] = mkv(0, 1, 7, 127, 127, 3, W(7,0,127), W(7,1,127), W(7,2,1), '0, 4'b0000, 8'h80);

    // Reset values
    reset = 1'b1;
    clear_inputs();
    bus.eng_busy = 1'b0;
    #1;
    chk("rst_eng_wr",     32'(bus.eng_wr), 32'd0);
    chk("rst_eng_voice",  32'(bus.eng_voice), 32'd0);
    chk("rst_eng_sel",    32'(bus.eng_sel), 32'd0);
    chk("rst_eng_data",   32'(bus.eng_data), 32'd0);
    chk("rst_gate",       32'(bus.gate), 32'd0);
    chk("rst_a_ready",    32'(bus.a_ready), 32'd1);
    chk("rst_b_ready",    32'(bus.b_ready), 32'd1);
    chk("rst_sched_idle", 32'(bus.sched_idle), 32'd1);
    @(negedge data_clk);
    @(negedge data_clk);
    reset = 1'b0;

    // Table: one event at a time, cycle-exact write sequence
    for (int t = 0; t < 7; t++) begin
      @(negedge data_clk);
      if (vt[t].port_b) begin
        chk($sformatf("vec%0d_ready", t), 32'(bus.b_ready), 32'd1);
        drive_b(vt[t].on, int'(vt[t].voice), int'(vt[t].key), int'(vt[t].vel));
      end else begin
        chk($sformatf("vec%0d_ready", t), 32'(bus.a_ready), 32'd1);
        drive_a(vt[t].on, int'(vt[t].voice), int'(vt[t].key), int'(vt[t].vel));
      end
      @(negedge data_clk);
      clear_inputs();
      chk($sformatf("vec%0d_grant_gap", t), 32'(bus.eng_wr), 32'd0);
      for (int i = 0; i < vt[t].nwr; i++) begin
        @(negedge data_clk);
        chk($sformatf("vec%0d_strobe%0d", t, i), 32'(bus.eng_wr), 32'd1);
        chk($sformatf("vec%0d_write%0d", t, i),
            32'({bus.eng_voice, bus.eng_sel, bus.eng_data}), 32'(vt[t].wr[i]));
        chk($sformatf("vec%0d_gate_dur%0d", t, i),
            32'(bus.gate[vt[t].voice]), 32'(vt[t].gv[i]));
      end
      @(negedge data_clk);
      chk($sformatf("vec%0d_end_wr", t), 32'(bus.eng_wr), 32'd0);
      chk($sformatf("vec%0d_end_idle", t), 32'(bus.sched_idle), 32'd1);
      chk($sformatf("vec%0d_end_gate", t), 32'(bus.gate), 32'(vt[t].gate_exp));
    end

    // Arbitration: A and B each push 3 events in the same cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge data_clk);
      chk($sformatf("arb_a_ready%0d", i), 32'(bus.a_ready), 32'd1);
      chk($sformatf("arb_b_ready%0d", i), 32'(bus.b_ready), 32'd1);
      drive_a(1'b1, i, 10 + i, 50);
      drive_b(1'b1, 4 + i, 20 + i, 60);
    end
    @(negedge data_clk);
    clear_inputs();
    wait_idle("arb_timeout", 200);
`ifdef KEY_SCHED_FIXED_PRIO_EN
    exp_keys[0] = 8'd10; exp_keys[1] = 8'd11; exp_keys[2] = 8'd12;
    exp_keys[3] = 8'd20; exp_keys[4] = 8'd21; exp_keys[5] = 8'd22;
`else
    exp_keys[0] = 8'd10; exp_keys[1] = 8'd20; exp_keys[2] = 8'd11;
    exp_keys[3] = 8'd21; exp_keys[4] = 8'd12; exp_keys[5] = 8'd22;
`endif
    chk("arb_write_count", 32'(wlog.size()), 32'd18);
    keys.delete();
    foreach (wlog[j]) if (wlog[j][9:8] == 2'd0) keys.push_back(wlog[j][7:0]);
    chk("arb_key_count", 32'(keys.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < keys.size()) chk($sformatf("arb_order%0d", i), 32'(keys[i]), 32'(exp_keys[i]));
      else                 chk($sformatf("arb_order%0d", i), 32'hFFFF, 32'(exp_keys[i]));
    end
    chk("arb_gate", 32'(bus.gate), 32'h77);

    // Stall: busy held for 5 cycles during WR_VEL
    wlog.delete();
    @(negedge data_clk);
    drive_a(1'b1, 3, 1, 2);
    @(negedge data_clk);
    clear_inputs();
    @(negedge data_clk);
    chk("stall_key", 32'({bus.eng_voice, bus.eng_sel, bus.eng_data}), 32'(W(3,0,1)));
    for (int i = 0; i < 6; i++) begin
      @(negedge data_clk);
      chk($sformatf("stall_hold_wr%0d", i), 32'(bus.eng_wr), 32'd1);
      chk($sformatf("stall_hold%0d", i),
          32'({bus.eng_voice, bus.eng_sel, bus.eng_data}), 32'(W(3,1,2)));
      bus.eng_busy = (i < 5);
    end
    @(negedge data_clk);
    chk("stall_gate_wr", 32'({bus.eng_wr, bus.eng_voice, bus.eng_sel, bus.eng_data}),
        32'({1'b1, W(3,2,1)}));
    @(negedge data_clk);
    chk("stall_end_wr", 32'(bus.eng_wr), 32'd0);
    chk("stall_end_gate", 32'(bus.gate), 32'h7F);
    cnt = 0;
    foreach (wlog[j]) if (wlog[j] == W(3,1,2)) cnt++;
    chk("stall_vel_once", 32'(cnt), 32'd1);

    // Full FIFO: B pushes back-to-back while the engine stalls
    do_reset();
    bus.eng_busy = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge data_clk);
      drive_b(1'b1, acc, 30 + acc, 40);
      if (bus.b_ready) acc++;
    end
    @(negedge data_clk);
    chk("full_b_ready", 32'(bus.b_ready), 32'd0);
    chk("full_accepted", 32'(acc), 32'd5);
    chk("full_a_ready", 32'(bus.a_ready), 32'd1);
    clear_inputs();
    bus.eng_busy = 1'b0;
    wait_idle("full_timeout", 300);
    chk("full_write_count", 32'(wlog.size()), 32'd15);
    keys.delete();
    foreach (wlog[j]) if (wlog[j][9:8] == 2'd0) keys.push_back(wlog[j][7:0]);
    for (int i = 0; i < 5; i++) begin
      if (i < keys.size()) chk($sformatf("full_key%0d", i), 32'(keys[i]), 32'(30 + i));
      else                 chk($sformatf("full_key%0d", i), 32'hFFFF, 32'(30 + i));
    end
    chk("full_gate", 32'(bus.gate), 32'h1F);

    // Reset during WR_KEY with two events queued
    bus.eng_busy = 1'b1;
    @(negedge data_clk);
    drive_a(1'b1, 6, 5, 9);
    @(negedge data_clk);
    drive_a(1'b1, 7, 6, 9);
    drive_b(1'b1, 1, 7, 9);
    @(negedge data_clk);
    clear_inputs();
    chk("rmid_in_wr_key", 32'({bus.eng_wr, bus.eng_sel, bus.eng_data}), 32'({1'b1, 2'd0, 8'd5}));
    @(negedge data_clk);
    reset = 1'b1;
    #1;
    chk("rmid_eng_wr", 32'(bus.eng_wr), 32'd0);
    chk("rmid_gate", 32'(bus.gate), 32'd0);
    chk("rmid_ready", 32'({bus.a_ready, bus.b_ready}), 32'd3);
    chk("rmid_idle", 32'(bus.sched_idle), 32'd1);
    @(negedge data_clk);
    reset = 1'b0;
    bus.eng_busy = 1'b0;
    wlog.delete();
    any_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge data_clk);
      if (bus.eng_wr) any_wr = 1'b1;
    end
    chk("rmid_no_write", 32'(any_wr), 32'd0);
    chk("rmid_log_empty", 32'(wlog.size()), 32'd0);
    chk("rmid_still_idle", 32'(bus.sched_idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
